// File: rtl/line_rasterizer.sv
// Bresenham line walker: accepts one endpoint pair per handshake, emits one pixel per cycle.
// Optional screen-bounds clipping is enabled by defining LINE_CLIP_EN.
module line_rasterizer #(
    parameter int CORDW = 16,
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic                    clock,
    input  logic                    io_aresetn,
    input  logic                    io_in_valid,
    output logic                    io_in_ready,
    input  logic signed [CORDW-1:0] io_x0,
    input  logic signed [CORDW-1:0] io_y0,
    input  logic signed [CORDW-1:0] io_x1,
    input  logic signed [CORDW-1:0] io_y1,
    output logic                    io_out_valid,
    input  logic                    io_out_ready,
    output logic signed [CORDW-1:0] io_out_x,
    output logic signed [CORDW-1:0] io_out_y,
    output logic                    io_out_last,
    output logic                    io_busy,
    output logic                    io_done
);

    // state | meaning
    // IDLE  | waiting for an endpoint pair
    // INIT  | deltas, step directions and initial error being computed
    // DRAW  | walking the segment, one pixel per handshake
    typedef enum logic [1:0] {IDLE, INIT, DRAW} state_t;

    localparam int DW  = CORDW + 1;
    localparam int EW  = CORDW + 2;
    localparam int E2W = CORDW + 3;
    localparam logic signed [CORDW-1:0] ONE   = CORDW'(1);
    localparam logic signed [DW-1:0]    H_LIM = DW'(H_RES);
    localparam logic signed [DW-1:0]    V_LIM = DW'(V_RES);

    state_t state, state_nx;

    logic signed [CORDW-1:0] x0_r, y0_r, x1_r, y1_r, cx, cy;
    logic signed [DW-1:0]    dx, dy;
    logic                    sx_neg, sy_neg;
    logic signed [EW-1:0]    err;
    logic                    done_r;

    logic signed [DW-1:0]  diff_x, diff_y, abs_x, abs_y, cx_w, cy_w;
    logic signed [E2W-1:0] e2, dx_e, dy_e;
    logic signed [EW-1:0]  dx_w, dy_w, err_nx;
    logic                  step_x, step_y, at_end, on_screen, visible, fire;

    assign diff_x = {x1_r[CORDW-1], x1_r} - {x0_r[CORDW-1], x0_r};
    assign diff_y = {y1_r[CORDW-1], y1_r} - {y0_r[CORDW-1], y0_r};
    assign abs_x  = diff_x[DW-1] ? -diff_x : diff_x;
    assign abs_y  = diff_y[DW-1] ? -diff_y : diff_y;

    // Both step decisions use the pre-update error; err absorbs both increments.
    assign e2     = {err[EW-1], err, 1'b0};
    assign dx_e   = {{2{dx[DW-1]}}, dx};
    assign dy_e   = {{2{dy[DW-1]}}, dy};
    assign dx_w   = {dx[DW-1], dx};
    assign dy_w   = {dy[DW-1], dy};
    assign step_x = (e2 >= dy_e);
    assign step_y = (e2 <= dx_e);
    assign err_nx = err + (step_x ? dy_w : {EW{1'b0}}) + (step_y ? dx_w : {EW{1'b0}});

    assign at_end    = (cx == x1_r) && (cy == y1_r);
    assign cx_w      = {cx[CORDW-1], cx};
    assign cy_w      = {cy[CORDW-1], cy};
    assign on_screen = !cx[CORDW-1] && !cy[CORDW-1] && (cx_w < H_LIM) && (cy_w < V_LIM);

`ifdef LINE_CLIP_EN
    assign visible = on_screen;
`else
    logic clip_unused;
    assign visible     = 1'b1;
    assign clip_unused = on_screen;
`endif

    // Off-screen pixels advance without waiting for the consumer.
    assign fire = (state == DRAW) && (visible ? io_out_ready : 1'b1);

    assign io_in_ready  = (state == IDLE);
    assign io_busy      = (state != IDLE);
    assign io_out_valid = (state == DRAW) && visible;
    assign io_out_last  = (state == DRAW) && visible && at_end;
    assign io_out_x     = cx;
    assign io_out_y     = cy;
    assign io_done      = done_r;

    always_ff @(posedge clock or negedge io_aresetn) begin
        if (!io_aresetn) state <= IDLE;
        else             state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (io_in_valid) state_nx = INIT;
            INIT:    state_nx = DRAW;
            DRAW:    if (fire && at_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge io_aresetn) begin
        if (!io_aresetn) begin
            x0_r   <= '0;
            y0_r   <= '0;
            x1_r   <= '0;
            y1_r   <= '0;
            cx     <= '0;
            cy     <= '0;
            dx     <= '0;
            dy     <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
            err    <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (io_in_valid) begin
                        x0_r <= io_x0;
                        y0_r <= io_y0;
                        x1_r <= io_x1;
                        y1_r <= io_y1;
                    end
                end
                INIT: begin
                    dx     <= abs_x;
                    dy     <= -abs_y;
                    sx_neg <= !(x0_r < x1_r);
                    sy_neg <= !(y0_r < y1_r);
                    err    <= {abs_x[DW-1], abs_x} - {abs_y[DW-1], abs_y};
                    cx     <= x0_r;
                    cy     <= y0_r;
                end
                DRAW: begin
                    if (fire) begin
                        if (at_end) begin
                            done_r <= 1'b1;
                        end else begin
                            if (step_x) cx <= sx_neg ? cx - ONE : cx + ONE;
                            if (step_y) cy <= sy_neg ? cy - ONE : cy + ONE;
                            err <= err_nx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
